instr_fetch: RTL and testbench

Instruction fetch and prefetch unit for the 16-bit multicycle processor. It sits between instruction memory and the processor's `instruction` input. It runs a sequential fetch PC and reads memory over a req/ack handshake. Fetched words are buffered in a small FIFO and presented under a valid/ready handshake driven by the control unit's IR-write strobe. Branch and jump redirects from the PC logic flush the buffer and any in-flight fetch.

---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/ifetch_fifo.sv | 57 +++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t  : fetch FSM states
//   OPC_HALT       : opcode value of the halt instruction
//   OPC_MSB/OPC_LSB: opcode field bounds inside a 16-bit instruction word
//   ifetch_entry_t : prefetch FIFO entry {addr, word}
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [3:0] OPC_HALT = 4'hF;
  localparam int         OPC_MSB  = 15;
  localparam int         OPC_LSB  = 12;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] word;
  } ifetch_entry_t;

  function automatic logic is_halt(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory-side and consumer-side handshakes of instr_fetch.
//   mem_req/mem_addr/mem_ack/mem_rdata : instruction memory req/ack bus
//   pc_load/pc_target                  : redirect from the PC logic
//   ir_ready/ir_valid/instruction/fetch_pc : head-word valid/ready handshake
// Modports: master = fetch unit, slave = memory + processor side.
interface instr_fetch_if #(parameter int AW = 16);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic          ir_ready;
  logic          ir_valid;
  logic [15:0]   instruction;
  logic [AW-1:0] fetch_pc;

  modport master (
    output mem_req, mem_addr, ir_valid, instruction, fetch_pc,
    input  mem_ack, mem_rdata, pc_load, pc_target, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_valid, instruction, fetch_pc,
    output mem_ack, mem_rdata, pc_load, pc_target, ir_ready
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous prefetch FIFO of {addr, word} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write an entry (accepted when not full, or full with pop)
//   pop        : drop the head entry (ignored when empty)
//   flush      : empty the FIFO; beats push and pop
//   head       : current head entry
//   count, full, empty : occupancy
module ifetch_fifo import ifetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ifetch_entry_t            din,
  output ifetch_entry_t            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  ifetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction prefetch unit with redirect flush.
//   CLOCK_50 : clock, all state on rising edge
//   reset    : asynchronous active-low reset
//   bus      : instr_fetch_if.master (memory req/ack, redirect, IR handshake)
// Optional build macro IFETCH_HALT_STOP_EN: a fetched halt opcode stops
// further requests until the next redirect; the halt word is still delivered.
//
// state   | meaning
// IDLE    | no request outstanding; waits for FIFO credit
// REQ     | request to mem_addr outstanding; data is kept
// DISCARD | request outstanding but redirected; data is dropped on ack
module instr_fetch import ifetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state;
  logic          mem_req_q;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] fpc;
  logic [AW-1:0] fpc_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          halt_next;
  logic          credit_next;
  ifetch_entry_t head;
  ifetch_entry_t din;

  // Only REQ keeps returned data; a redirect in the ack cycle drops it.
  assign push = (state == REQ) && bus.mem_ack && !bus.pc_load && (!full || pop);
  assign pop  = !empty && bus.ir_ready && !bus.pc_load;
  assign din  = '{addr: 16'(mem_addr_q), word: bus.mem_rdata};

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.pc_load),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    count_next = count;
    fpc_next   = fpc;
    if (bus.pc_load) begin
      count_next = '0;
      fpc_next   = bus.pc_target;
    end else begin
      if (push && !pop)      count_next = count + 1'b1;
      else if (!push && pop) count_next = count - 1'b1;
      if (push) fpc_next = fpc + 1'b1;
    end
  end

`ifdef IFETCH_HALT_STOP_EN
  logic halted;
  assign halt_next = bus.pc_load ? 1'b0 :
                     (push && is_halt(bus.mem_rdata)) ? 1'b1 : halted;
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) halted <= 1'b0;
    else        halted <= halt_next;
  end
`else
  assign halt_next = 1'b0;
`endif

  // Credit is judged on next-cycle occupancy, so a new request never
  // overcommits the FIFO even while a pop or push lands this cycle.
  assign credit_next = (count_next < DEPTH_C) && !halt_next;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fpc        <= '0;
    end else begin
      fpc <= fpc_next;
      case (state)
        IDLE: begin
          if (credit_next) begin
            state      <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fpc_next;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (!bus.pc_load && credit_next) begin
              mem_addr_q <= fpc_next;
            end else begin
              state     <= IDLE;
              mem_req_q <= 1'b0;
            end
          end else if (bus.pc_load) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.mem_ack) begin
            if (credit_next) begin
              state      <= REQ;
              mem_addr_q <= fpc_next;
            end else begin
              state     <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.ir_valid    = !empty;
  assign bus.instruction = empty ? 16'h0000 : head.word;
  assign bus.fetch_pc    = empty ? '0 : AW'(head.addr);
endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model of the fetch stream.
module tb_instr_fetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.AW(16)) bus();

  instr_fetch #(.DEPTH(DEPTH), .AW(16)) dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] exp_pc;     // address of the next word the consumer must see
  logic [15:0] exp_fetch;  // address the next fresh request must carry
  int          occ;        // buffered words
  int          n_pops;
  logic        in_txn;
  logic        stale;
  logic [15:0] held_addr;
  int          wait_left;
  int          max_wait = 0;
  int          forced_wait = -1;
  logic        halt_on = 1'b0;
  logic [15:0] halt_addr = 16'h0;
  logic [15:0] req_log[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (halt_on && a == halt_addr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  task automatic model_init();
    exp_pc = 16'h0; exp_fetch = 16'h0; occ = 0;
    in_txn = 1'b0; stale = 1'b0; held_addr = 16'h0; wait_left = 0;
    req_log.delete();
  endtask

  // One clock: check outputs settled after the last edge, play memory,
  // advance the model, and drive this cycle's inputs.
  task automatic step(input logic ld, input logic [15:0] tgt, input logic rdy);
    logic ack, push, pop;
    @(negedge clk);
    check("ir_valid", bus.ir_valid, occ != 0);
    if (bus.ir_valid) begin
      check("fetch_pc", bus.fetch_pc, exp_pc);
      check("instruction", bus.instruction, memf(exp_pc));
    end
    check("credit", (occ + int'(bus.mem_req)) <= DEPTH, 1'b1);
    ack = 1'b0;
    push = 1'b0;
    if (!bus.mem_req) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn = 1'b1;
        stale = 1'b0;
        held_addr = bus.mem_addr;
        req_log.push_back(bus.mem_addr);
        check("req_addr", bus.mem_addr, exp_fetch);
        wait_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, max_wait));
        forced_wait = -1;
      end else begin
        check("addr_hold", bus.mem_addr, held_addr);
      end
      if (wait_left == 0) begin
        ack = 1'b1;
        in_txn = 1'b0;
        push = !stale;
      end else begin
        wait_left--;
      end
    end
    pop = bus.ir_valid && rdy && !ld;
    if (ld) begin
      if (bus.mem_req && !ack) stale = 1'b1;
      exp_fetch = tgt;
      exp_pc = tgt;
      occ = 0;
    end else begin
      if (push) exp_fetch++;
      if (pop) begin exp_pc++; n_pops++; end
      occ = occ + int'(push) - int'(pop);
    end
    bus.mem_ack = ack;
    bus.mem_rdata = ack ? memf(bus.mem_addr) : 16'($urandom);
    bus.pc_load = ld;
    bus.pc_target = tgt;
    bus.ir_ready = rdy;
  endtask

  // Asserts reset at a falling edge (ack asserted to show it is ignored),
  // checks the outputs clear at once, then releases.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'hABCD;
    #1;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_ir_valid", bus.ir_valid, 1'b0);
    check("rst_instruction", bus.instruction, 16'h0);
    check("rst_fetch_pc", bus.fetch_pc, 16'h0);
    repeat (2) @(negedge clk);
    bus.mem_ack = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_target = 16'h0;
    bus.ir_ready = 1'b0;
    model_init();
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    bus.pc_load = 1'b0; bus.pc_target = 16'h0; bus.ir_ready = 1'b0;
    n_pops = 0;
    model_init();

    // Zero-wait streaming from reset
    max_wait = 0;
    do_reset();
    step(1'b0, 16'h0, 1'b1);
    check("req_after_reset", bus.mem_req, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1);
      check("stream_instr", bus.instruction, 16'h1000 + 16'(i));
      check("stream_pc", bus.fetch_pc, 16'(i));
    end

    // Credit limit with a stalled consumer
    do_reset();
    repeat (8) step(1'b0, 16'h0, 1'b0);
    check("credit_reqs", req_log.size(), DEPTH);
    for (int i = 0; i < req_log.size(); i++) check("credit_addr", req_log[i], 16'(i));
    check("credit_idle", bus.mem_req, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b0);
    check("credit_one_more", req_log.size(), DEPTH + 1);
    if (req_log.size() > DEPTH) check("credit_addr4", req_log[DEPTH], 16'h4);

    // Redirect during a slow fetch
    do_reset();
    forced_wait = 3;
    step(1'b1, 16'h0200, 1'b0);
    guard = 0;
    do begin step(1'b0, 16'h0, 1'b0); guard++; end while (!bus.ir_valid && guard < 20);
    check("discard_timeout", guard < 20, 1'b1);
    check("discard_first_pc", bus.fetch_pc, 16'h0200);
    check("discard_first_word", bus.instruction, 16'h1200);
    if (req_log.size() > 1) check("discard_req", req_log[1], 16'h0200);

    // Redirect and ready together with 3 words buffered
    do_reset();
    guard = 0;
    while (occ != 3 && guard < 20) begin step(1'b0, 16'h0, 1'b0); guard++; end
    check("fill3_timeout", guard < 20, 1'b1);
    step(1'b1, 16'h0040, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    check("flush_empty", bus.ir_valid, 1'b0);
    guard = 0;
    while (!bus.ir_valid && guard < 20) begin step(1'b0, 16'h0, 1'b1); guard++; end
    check("flush_timeout", guard < 20, 1'b1);
    check("flush_first_pc", bus.fetch_pc, 16'h0040);

    // Address wrap
    do_reset();
    repeat (2) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'hFFFE, 1'b1);
    req_log.delete();
    repeat (6) step(1'b0, 16'h0, 1'b1);
    check("wrap_cnt", req_log.size() >= 3, 1'b1);
    if (req_log.size() >= 3) begin
      check("wrap_a0", req_log[0], 16'hFFFE);
      check("wrap_a1", req_log[1], 16'hFFFF);
      check("wrap_a2", req_log[2], 16'h0000);
    end

    // Halt opcode at address 2
    halt_on = 1'b1;
    halt_addr = 16'h0002;
    do_reset();
    repeat (10) step(1'b0, 16'h0, 1'b1);
`ifdef IFETCH_HALT_STOP_EN
    check("halt_reqs", req_log.size(), 3);
    check("halt_idle", bus.mem_req, 1'b0);
    step(1'b1, 16'h0010, 1'b1);
    repeat (4) step(1'b0, 16'h0, 1'b1);
    check("halt_resume", req_log.size() > 3, 1'b1);
    if (req_log.size() > 3) check("halt_resume_addr", req_log[3], 16'h0010);
`else
    check("nohalt_more", req_log.size() > 3, 1'b1);
    if (req_log.size() > 3) check("nohalt_addr3", req_log[3], 16'h0003);
`endif
    halt_on = 1'b0;

    // Randomized traffic with a reset in the middle
    max_wait = 3;
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        ld;
      logic [15:0] tgt;
      if (i == 1500) begin
        guard = 0;
        while (!bus.mem_req && guard < 20) begin step(1'b0, 16'h0, 1'b0); guard++; end
        do_reset();
      end
      ld  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      step(ld, tgt, $urandom_range(0, 2) != 0);
    end
    check("random_progress", n_pops > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
